// File: rtl/cpu_mpu_regions.sv
// cpu_mpu_regions: memory protection unit with up to 16 power-of-two regions.
// The lowest-index enabled region that matches the request decides; user-mode
// accesses are denied on a miss or a missing permission. The first denial is
// kept as a sticky fault record, and a later denial only raises the overflow flag.
// Optional feature macro: MPU_FAULT_COUNT_EN builds the saturating deny counter.
// When the macro is not defined, fault_count is tied to 0.
module cpu_mpu_regions #(
  parameter int NUM_REGIONS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        supervisor,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_exec,
  input  logic [31:0] req_addr,
  input  logic        cfg_write,
  input  logic [3:0]  cfg_index,
  input  logic [31:0] cfg_data,
  output logic [31:0] cfg_rdata,
  output logic        resp_valid,
  output logic        resp_deny,
  output logic        fault_valid,
  output logic [31:0] fault_addr,
  output logic [1:0]  fault_type,
  output logic        fault_overflow,
  input  logic        fault_clear,
  output logic [15:0] fault_count
);

  typedef enum logic [1:0] {
    ACC_READ  = 2'd0,
    ACC_WRITE = 2'd1,
    ACC_EXEC  = 2'd2
  } acc_e;

  // Descriptor bit positions.
  localparam int EN_BIT = 11;
  localparam int X_BIT  = 10;
  localparam int W_BIT  = 9;
  localparam int R_BIT  = 8;

  logic [31:0] regions [NUM_REGIONS];
  acc_e        acc;
  logic        hit_any;
  logic        allowed;
  logic        deny;
  logic [19:0] mask;

  // The low page-offset bits never take part in the region match.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[11:0];

  // Descriptor storage. An out-of-range index matches no slot, so the write is dropped.
  // NOTE: the descriptors must be cleared by reset, so this array is reset like
  // ordinary flops and cannot be mapped onto a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) regions[i] <= '0;
    end else if (cfg_write) begin
      for (int i = 0; i < NUM_REGIONS; i++)
        if (cfg_index == 4'(i)) regions[i] <= cfg_data;
    end
  end

  // Combinational descriptor readback. An out-of-range index reads as 0.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    cfg_rdata = '0;
    for (int i = 0; i < NUM_REGIONS; i++)
      if (cfg_index == 4'(i)) cfg_rdata = regions[i];
  end

  // Access check. It reads the stored descriptors, so a descriptor written in
  // the same cycle takes effect from the next request onward.
  always_comb begin
    if (req_write)     acc = ACC_WRITE;  // write+exec is treated as write
    else if (req_exec) acc = ACC_EXEC;
    else               acc = ACC_READ;
    hit_any = 1'b0;
    allowed = 1'b0;
    mask    = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      mask = 20'hFFFFF << regions[i][3:0];
      if (!hit_any && regions[i][EN_BIT] &&
          ((req_addr[31:12] & mask) == (regions[i][31:12] & mask))) begin
        hit_any = 1'b1;
        case (acc)
          ACC_WRITE: allowed = regions[i][W_BIT];
          ACC_EXEC:  allowed = regions[i][X_BIT];
          default:   allowed = regions[i][R_BIT];
        endcase
      end
    end
    deny = req_valid && !supervisor && !allowed;
  end

  // Registered response, one cycle after the request.
  // NOTE: sequential state always uses non-blocking assignments, so every flop
  // samples the values present before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_deny  <= 1'b0;
    end else begin
      resp_valid <= req_valid;
      resp_deny  <= deny;
    end
  end

  // Sticky fault record. A new denial wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_valid    <= 1'b0;
      fault_addr     <= '0;
      fault_type     <= '0;
      fault_overflow <= 1'b0;
    end else if (deny && (!fault_valid || fault_clear)) begin
      fault_valid    <= 1'b1;
      fault_addr     <= req_addr;
      fault_type     <= acc;
      fault_overflow <= 1'b0;
    end else if (deny) begin
      fault_overflow <= 1'b1;
    end else if (fault_clear) begin
      fault_valid    <= 1'b0;
      fault_addr     <= '0;
      fault_type     <= '0;
      fault_overflow <= 1'b0;
    end
  end

`ifdef MPU_FAULT_COUNT_EN
  // Saturating count of denied requests. fault_clear does not reset it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             fault_count <= '0;
    else if (deny && fault_count != 16'hFFFF) fault_count <= fault_count + 16'd1;
  end
`else
  assign fault_count = '0;
`endif

endmodule

// File: tb/tb_cpu_mpu_regions.sv
// Directed self-checking bench for cpu_mpu_regions (built with NUM_REGIONS=12
// so that out-of-range descriptor indices can be exercised).
module tb_cpu_mpu_regions;

`ifdef MPU_FAULT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        supervisor = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_exec = 1'b0;
  logic [31:0] req_addr = '0;
  logic        cfg_write = 1'b0;
  logic [3:0]  cfg_index = '0;
  logic [31:0] cfg_data = '0;
  logic [31:0] cfg_rdata;
  logic        resp_valid;
  logic        resp_deny;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic [1:0]  fault_type;
  logic        fault_overflow;
  logic        fault_clear = 1'b0;
  logic [15:0] fault_count;

  int tests = 0;
  int fails = 0;

  cpu_mpu_regions #(.NUM_REGIONS(12)) dut (
    .clk(clk), .rst_n(rst_n), .supervisor(supervisor), .req_valid(req_valid),
    .req_write(req_write), .req_exec(req_exec), .req_addr(req_addr),
    .cfg_write(cfg_write), .cfg_index(cfg_index), .cfg_data(cfg_data),
    .cfg_rdata(cfg_rdata), .resp_valid(resp_valid), .resp_deny(resp_deny),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_type(fault_type),
    .fault_overflow(fault_overflow), .fault_clear(fault_clear),
    .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic sup, input logic wr, input logic ex, input logic [31:0] addr);
    req_valid  = 1'b1;
    supervisor = sup;
    req_write  = wr;
    req_exec   = ex;
    req_addr   = addr;
  endtask

  task automatic idle();
    req_valid  = 1'b0;
    supervisor = 1'b0;
    req_write  = 1'b0;
    req_exec   = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] idx, input logic [31:0] data);
    cfg_write = 1'b1;
    cfg_index = idx;
    cfg_data  = data;
    tick();
    cfg_write = 1'b0;
  endtask

  task automatic clear_faults();
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_deny", resp_deny, 0);
    check("rst_fault_valid", fault_valid, 0);
    check("rst_fault_count", fault_count, 0);
    check("rst_desc0", cfg_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // User read with no regions configured is denied and becomes the first fault
    req(1'b0, 1'b0, 1'b0, 32'h0000_1000);
    tick();
    idle();
    check("r30_resp_valid", resp_valid, 1);
    check("r30_resp_deny", resp_deny, 1);
    check("r30_fault_valid", fault_valid, 1);
    check("r30_fault_addr", fault_addr, 32'h0000_1000);
    check("r30_fault_type", fault_type, 0);
    check("r30_count", fault_count, CNT_EN ? 32'd1 : 32'd0);
    tick();
    check("idle_resp_valid", resp_valid, 0);
    check("idle_resp_deny", resp_deny, 0);
    clear_faults();
    check("clr_fault_valid", fault_valid, 0);
    check("clr_fault_addr", fault_addr, 0);

    // 64K read/write region
    cfg(4'd0, 32'h0010_0B04);
    check("desc0_readback", cfg_rdata, 32'h0010_0B04);
    req(1'b0, 1'b1, 1'b0, 32'h0010_F004);
    tick();
    check("r31_write_deny", resp_deny, 0);
    req(1'b0, 1'b1, 1'b1, 32'h0010_F004);  // write+exec acts as a write
    tick();
    check("r31_wx_deny", resp_deny, 0);
    req(1'b0, 1'b0, 1'b1, 32'h0010_F004);
    tick();
    check("r31_exec_deny", resp_deny, 1);
    check("r31_fault_type", fault_type, 2);
    check("r31_fault_addr", fault_addr, 32'h0010_F004);
    req(1'b0, 1'b0, 1'b0, 32'h0011_0000);  // just past the 64K window
    tick();
    idle();
    check("r31_miss_deny", resp_deny, 1);
    check("r31_ovf", fault_overflow, 1);
    check("r31_addr_kept", fault_addr, 32'h0010_F004);
    check("r31_type_kept", fault_type, 2);
    clear_faults();
    check("r31_clr_ovf", fault_overflow, 0);

    // Fixed priority: region 0 with no permissions shadows the RWX region 1
    cfg(4'd0, 32'h0000_0808);
    cfg(4'd1, 32'h0000_0F08);
    req(1'b0, 1'b0, 1'b0, 32'h0008_0000);
    tick();
    idle();
    check("r32_prio_deny", resp_deny, 1);
    cfg(4'd0, 32'h0000_0000);
    req(1'b0, 1'b0, 1'b0, 32'h0008_0000);
    tick();
    idle();
    check("r32_region1_deny", resp_deny, 0);

    // Back-to-back denials followed by a clear that coincides with a denial
    cfg(4'd1, 32'h0000_0000);
    clear_faults();
    req(1'b0, 1'b0, 1'b0, 32'h0000_0100);
    tick();
    check("r33_first_addr", fault_addr, 32'h0000_0100);
    check("r33_first_ovf", fault_overflow, 0);
    req(1'b0, 1'b0, 1'b0, 32'h0000_0200);
    tick();
    check("r33_second_deny", resp_deny, 1);
    check("r33_second_addr", fault_addr, 32'h0000_0100);
    check("r33_second_ovf", fault_overflow, 1);
    req(1'b0, 1'b1, 1'b0, 32'h0000_0300);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    idle();
    check("r33_third_addr", fault_addr, 32'h0000_0300);
    check("r33_third_ovf", fault_overflow, 0);
    check("r33_third_valid", fault_valid, 1);
    check("r33_third_type", fault_type, 1);
    clear_faults();
    check("r33_cleared", fault_valid, 0);

    // A descriptor write applies only from the following cycle
    req(1'b0, 1'b0, 1'b0, 32'h2000_0000);
    cfg_write = 1'b1;
    cfg_index = 4'd0;
    cfg_data  = 32'h2000_0B00;
    tick();
    cfg_write = 1'b0;
    check("r34_prewrite_deny", resp_deny, 1);
    tick();
    check("r34_postwrite_deny", resp_deny, 0);
    req(1'b0, 1'b0, 1'b0, 32'h2000_1000);  // 4K region: the next page misses
    tick();
    check("r34_4k_edge_deny", resp_deny, 1);
    req(1'b1, 1'b0, 1'b0, 32'hFFFF_F000);
    tick();
    idle();
    check("r34_super_valid", resp_valid, 1);
    check("r34_super_deny", resp_deny, 0);

    // Base low bits below the region size are ignored
    cfg(4'd2, 32'h3000_5B04);
    req(1'b0, 1'b0, 1'b0, 32'h3000_0000);
    tick();
    idle();
    check("base_lowbits_deny", resp_deny, 0);

    // Descriptor index bounds with NUM_REGIONS=12
    cfg(4'd11, 32'h0000_0C10);
    check("desc11_readback", cfg_rdata, 32'h0000_0C10);
    cfg(4'd12, 32'hFFFF_FFFF);
    check("desc12_reads_zero", cfg_rdata, 0);

    // Denial burst: the counter saturates when the feature is built, otherwise it stays 0
    cfg_index = 4'd0;
    clear_faults();
    req(1'b0, 1'b0, 1'b0, 32'h4000_0000);
    for (int i = 0; i < (CNT_EN ? 65537 : 20); i++) tick();
    check("burst_count", fault_count, CNT_EN ? 32'h0000_FFFF : 32'd0);
    check("burst_ovf", fault_overflow, 1);
    check("burst_addr", fault_addr, 32'h4000_0000);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    check("burst_clr_ovf", fault_overflow, 0);
    check("burst_count_held", fault_count, CNT_EN ? 32'h0000_FFFF : 32'd0);

    // Reset asserted mid-burst clears everything without waiting for an edge
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_resp_deny", resp_deny, 0);
    check("mid_rst_fault_valid", fault_valid, 0);
    check("mid_rst_fault_addr", fault_addr, 0);
    check("mid_rst_fault_ovf", fault_overflow, 0);
    check("mid_rst_count", fault_count, 0);
    check("mid_rst_desc0", cfg_rdata, 0);
    tick();
    check("in_rst_no_resp", resp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    idle();
    check("post_rst_resp_valid", resp_valid, 1);
    check("post_rst_resp_deny", resp_deny, 1);
    check("post_rst_fault_addr", fault_addr, 32'h4000_0000);
    check("post_rst_count", fault_count, CNT_EN ? 32'd1 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
